reg_access_ctrl: RTL
====================

Name: reg_access_ctrl

Overview:
- Command-frame controller directly upstream of the 16x8 register file. It consumes parallel bytes from the UART RX deserializer and drives the register-file write/read strobes.
- Read data returned by the register file is pushed into the TX FIFO.
- Single clock domain (REF_CLK side). Frames are byte-oriented: command byte, address byte, then a data byte for writes only.

Parameters:
- DATA_WIDTH, 8, width of RX bytes, register data and TX data
- ADDR_WIDTH, 4, register-file address width
- CMD_WR, 8'hAA, write-frame command code
- CMD_RD, 8'hBB, read-frame command code
- RD_TIMEOUT, 4, maximum cycles in RD_WAIT before the read is abandoned

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA valid
- WrEn  out  1  register-file write strobe
- RdEn  out  1  register-file read strobe
- Address  out  ADDR_WIDTH  register-file address
- WrData  out  DATA_WIDTH  register-file write data
- RdData  in  DATA_WIDTH  register-file read data
- RdData_VLD  in  1  register-file read-data valid
- TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO
- TX_D_VLD  out  1  one-cycle TX FIFO push strobe
- FIFO_FULL  in  1  TX FIFO full; no push allowed
- FRAME_ERR  out  1  one-cycle pulse when a frame is dropped

Behaviour:
- Reset: the async-low RST sends the FSM to IDLE and clears all outputs to 0, together with the timeout counter and the read-data holding register. A reset mid-frame discards the frame.
- All outputs are registered. WrEn and RdEn are never high in the same cycle, and each is high for exactly one cycle per frame.
- Address and WrData hold their last value between frames.
- RX bytes are sampled only when RX_D_VLD=1. Cycles without a strobe leave the state unchanged; there is no inter-byte timeout.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_PUSH.
- IDLE:
  - byte==CMD_WR -> WR_ADDR
  - byte==CMD_RD -> RD_ADDR
  - any other byte is ignored; stay in IDLE with no pulse.
- WR_ADDR: on a byte, Address <= byte[ADDR_WIDTH-1:0] (upper bits discarded; see optional feature) -> WR_DATA.
- WR_DATA: a byte in cycle N gives WrData=byte and WrEn=1 in cycle N+1, then IDLE.
- RD_ADDR: a byte in cycle N gives Address loaded and RdEn=1 in cycle N+1, then RD_WAIT. The timeout counter clears.
- RD_WAIT:
  - RdData_VLD=1 captures RdData -> TX_PUSH. Nominally this is cycle N+2.
  - Otherwise the counter increments. When it reaches RD_TIMEOUT: FRAME_ERR pulse, then IDLE.
- TX_PUSH:
  - If FIFO_FULL=0: TX_P_DATA=captured data and TX_D_VLD=1 for one cycle, then IDLE. Nominal push is cycle N+3.
  - If FIFO_FULL=1: hold in TX_PUSH with TX_D_VLD=0 and the data retained, for as long as FIFO_FULL stays high.
- RX_D_VLD while in RD_WAIT or TX_PUSH: the byte is dropped without starting a new frame, and FRAME_ERR pulses one cycle.
- A back-to-back frame may start in the cycle after the FSM returns to IDLE.

Optional Feature:
- Macro: ADDR_RANGE_CHECK_EN
- Defined:
  - In WR_ADDR or RD_ADDR, an address byte with any bit above ADDR_WIDTH-1 set aborts the frame: FRAME_ERR pulses one cycle, the FSM goes to IDLE, no WrEn/RdEn is issued and Address is unchanged.
  - For an aborted read, error byte 8'hEE is pushed to the TX FIFO under the same FIFO_FULL rule as TX_PUSH.
- Undefined: upper address bits are silently truncated and there is no error path.

Test Plan:
- Write: bytes AA,05,3C -> WrEn=1 one cycle after the 3C strobe, with Address=5 and WrData=3C; RdEn stays 0.
- Read: bytes BB,02 with RF returning 81 one cycle after RdEn -> RdEn one cycle after the 02 strobe, then TX_P_DATA=81 with TX_D_VLD=1 at +3 cycles.
- Backpressure: read of addr 3 (data 20) with FIFO_FULL=1 for 5 cycles -> no TX_D_VLD while full; single push of 20 on the cycle FIFO_FULL=0.
- Errors: unknown byte 55 in IDLE -> no strobes. RdData_VLD held 0 for 4 cycles -> FRAME_ERR pulse, back to IDLE. Byte arriving in RD_WAIT -> FRAME_ERR and the byte is dropped.
- Reset: RST low after AA,07 -> all outputs 0; next frame AA,01,FF writes addr 1 normally.
- ADDR_RANGE_CHECK_EN: AA,15,xx -> FRAME_ERR, no WrEn. BB,15 -> TX byte EE. Without the macro, AA,15,9A writes 9A to addr 5.

Source files
------------

// File: rtl/reg_access_ctrl_if.sv
// Byte-stream, register-file and TX-FIFO signals around the command-frame controller.
// The controller takes the master modport; the surrounding blocks take the slave modport.
interface reg_access_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] WrData;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  RdData_VLD;
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  FIFO_FULL;
    logic                  FRAME_ERR;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_VLD, FIFO_FULL,
        output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, FRAME_ERR
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_VLD, FIFO_FULL,
        input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, FRAME_ERR
    );
endinterface

// File: rtl/reg_access_ctrl.sv
// Command-frame controller between the UART RX byte stream, the register file and the TX FIFO.
// Optional ADDR_RANGE_CHECK_EN: out-of-range address bytes abort the frame (reads answer 8'hEE).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a command byte (CMD_WR / CMD_RD)
// WR_ADDR   | write frame, waiting for the address byte
// WR_DATA   | write frame, waiting for the data byte
// RD_ADDR   | read frame, waiting for the address byte
// RD_WAIT   | read strobe issued, waiting for RdData_VLD or timeout
// TX_PUSH   | read byte held, pushing it to the TX FIFO when not full
module reg_access_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] CMD_WR     = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] CMD_RD     = 8'hBB,
    parameter int                    RD_TIMEOUT = 4
) (
    input  logic               CLK,
    input  logic               RST,
    reg_access_ctrl_if.master  bus
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] ERR_BYTE = DATA_WIDTH'(8'hEE);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_ADDR = 3'd1;
    localparam logic [2:0] S_WR_DATA = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_TX_PUSH = 3'd5;

    logic [2:0]            state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [DATA_WIDTH-1:0] hold_q,      hold_d;
    logic                  wr_en_q,     wr_en_d;
    logic                  rd_en_q,     rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q,   wr_data_d;
    logic [DATA_WIDTH-1:0] tx_data_q,   tx_data_d;
    logic                  tx_vld_q,    tx_vld_d;
    logic                  frame_err_q, frame_err_d;

    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  rx_vld;
    logic                  addr_bad;

    assign rx_byte = bus.RX_P_DATA;
    assign rx_vld  = bus.RX_D_VLD;

`ifdef ADDR_RANGE_CHECK_EN
    assign addr_bad = |rx_byte[DATA_WIDTH-1:ADDR_WIDTH];
`else
    assign addr_bad = 1'b0;
`endif

    // TX_D_VLD is registered, so the FIFO_FULL seen on the launching edge decides each push.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        tx_data_d   = tx_data_q;
        tx_vld_d    = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_vld) begin
                    if (rx_byte == CMD_WR) begin
                        state_d = S_WR_ADDR;
                    end else if (rx_byte == CMD_RD) begin
                        state_d = S_RD_ADDR;
                    end
                end
            end

            S_WR_ADDR: begin
                if (rx_vld) begin
                    if (addr_bad) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        addr_d  = rx_byte[ADDR_WIDTH-1:0];
                        state_d = S_WR_DATA;
                    end
                end
            end

            S_WR_DATA: begin
                if (rx_vld) begin
                    wr_data_d = rx_byte;
                    wr_en_d   = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            S_RD_ADDR: begin
                if (rx_vld) begin
                    if (addr_bad) begin
                        frame_err_d = 1'b1;
                        hold_d      = ERR_BYTE;
                        tx_data_d   = ERR_BYTE;
                        tx_vld_d    = ~bus.FIFO_FULL;
                        state_d     = S_TX_PUSH;
                    end else begin
                        addr_d  = rx_byte[ADDR_WIDTH-1:0];
                        rd_en_d = 1'b1;
                        cnt_d   = '0;
                        state_d = S_RD_WAIT;
                    end
                end
            end

            S_RD_WAIT: begin
                frame_err_d = rx_vld;
                if (bus.RdData_VLD) begin
                    hold_d    = bus.RdData;
                    tx_data_d = bus.RdData;
                    tx_vld_d  = ~bus.FIFO_FULL;
                    state_d   = S_TX_PUSH;
                end else if (cnt_q == CNT_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_TX_PUSH: begin
                frame_err_d = rx_vld;
                if (tx_vld_q) begin
                    state_d = S_IDLE;
                end else if (!bus.FIFO_FULL) begin
                    tx_data_d = hold_q;
                    tx_vld_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            tx_data_q   <= '0;
            tx_vld_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            tx_data_q   <= tx_data_d;
            tx_vld_q    <= tx_vld_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.WrEn      = wr_en_q;
    assign bus.RdEn      = rd_en_q;
    assign bus.Address   = addr_q;
    assign bus.WrData    = wr_data_q;
    assign bus.TX_P_DATA = tx_data_q;
    assign bus.TX_D_VLD  = tx_vld_q;
    assign bus.FRAME_ERR = frame_err_q;

endmodule
